// File: rtl/ble_dqpsk_seq_pkg.sv
// Shared types and constants for the BLE DQPSK transmit burst sequencer.
package ble_dqpsk_seq_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_GAP,
    ST_READ,
    ST_DONE
  } seq_state_t;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_CFG      = 2'd1;
  localparam logic [1:0] ERR_UNDERRUN = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

endpackage

// File: rtl/ble_byte_serializer.sv
// Byte-to-bit serializer: shift register plus one skid byte, LSB first,
// with a remaining-bit counter and underrun detection.
module ble_byte_serializer
  import ble_dqpsk_seq_pkg::*;
#(
  parameter int CNT_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [CNT_W-1:0]  sym_count,
  input  logic              active,
  input  logic              byte_valid,
  input  logic [BYTE_W-1:0] byte_data,
  output logic              byte_ready,
  output logic              bit_valid,
  output logic              bit_data,
  output logic              last_bit,
  output logic              underrun
);

  logic [BYTE_W-1:0] shift_q;
  logic [BYTE_W-1:0] skid_q;
  logic [3:0]        shift_cnt;
  logic              skid_full;
  logic [CNT_W:0]    bits_left;
  logic              accept;
  logic              empties;

  assign bit_valid  = active && (shift_cnt != 4'd0) && (bits_left != '0);
  assign bit_data   = shift_q[0];
  // Only fetch another byte while the buffered bits fall short of what remains.
  assign byte_ready = active && !skid_full &&
                      (bits_left > {{(CNT_W-3){1'b0}}, shift_cnt});
  assign accept     = byte_valid && byte_ready;
  assign empties    = (shift_cnt == 4'd0) || (bit_valid && shift_cnt == 4'd1);
  assign last_bit   = bit_valid && (bits_left == (CNT_W+1)'(1));
  // Last buffered bit leaving with nothing behind it would open a gap in valid_in.
  assign underrun   = bit_valid && (shift_cnt == 4'd1) &&
                      (bits_left > (CNT_W+1)'(1)) && !skid_full && !accept;

  always_ff @(posedge clk) begin
    if (reset) begin
      shift_q   <= '0;
      skid_q    <= '0;
      shift_cnt <= 4'd0;
      skid_full <= 1'b0;
      bits_left <= '0;
    end else if (load) begin
      bits_left <= {sym_count, 1'b0};
      shift_cnt <= 4'd0;
      skid_full <= 1'b0;
    end else if (!active) begin
      shift_cnt <= 4'd0;
      skid_full <= 1'b0;
    end else begin
      if (bit_valid) begin
        shift_q   <= shift_q >> 1;
        shift_cnt <= shift_cnt - 4'd1;
        bits_left <= bits_left - 1'b1;
      end
      if (empties) begin
        if (skid_full) begin
          shift_q   <= skid_q;
          shift_cnt <= 4'd8;
          skid_full <= 1'b0;
        end else if (accept) begin
          shift_q   <= byte_data;
          shift_cnt <= 4'd8;
        end
      end else if (accept) begin
        skid_q    <= byte_data;
        skid_full <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/ble_dqpsk_tx_sequencer.sv
// Burst controller for the BLE DQPSK modulator: feeds the bit stream,
// waits the idle gap, then runs the read phase until the modulator drains.
module ble_dqpsk_tx_sequencer
  import ble_dqpsk_seq_pkg::*;
#(
  parameter int CNT_W     = 10,
  parameter int RAM_DEPTH = 512,
  parameter int GAP_CYC   = 1,
  parameter int TIMEOUT   = 4096
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] sym_count,
  input  logic             byte_valid,
  input  logic [7:0]       byte_data,
  output logic             byte_ready,
  output logic             mod_valid_in,
  output logic             mod_data_in,
  output logic             mod_enable,
  input  logic             mod_valid_out,
  input  logic             mod_finished,
  output logic             busy,
  output logic             done,
  output logic [1:0]       err_code
);

  localparam int GAP_W = $clog2(GAP_CYC + 1);
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W:0] MAX_SYM = (CNT_W+1)'(RAM_DEPTH);

  seq_state_t       state_q, state_d;
  logic [GAP_W-1:0] gap_cnt;
  logic [TMO_W-1:0] tmo_cnt;
  logic             seen_out;
  logic [1:0]       err_q;
  logic             cfg_ok;
  logic             load;
  logic             bit_valid, bit_data, last_bit, underrun;
  logic             read_exit;

  assign cfg_ok    = (sym_count != '0) && ({1'b0, sym_count} <= MAX_SYM);
  assign load      = (state_q == ST_IDLE) && start && cfg_ok;
  assign read_exit = seen_out && mod_finished;

  ble_byte_serializer #(.CNT_W(CNT_W)) u_ser (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .sym_count  (sym_count),
    .active     (state_q == ST_LOAD),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .bit_valid  (bit_valid),
    .bit_data   (bit_data),
    .last_bit   (last_bit),
    .underrun   (underrun)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = cfg_ok ? ST_LOAD : ST_DONE;
      ST_LOAD: if (last_bit || underrun) state_d = ST_GAP;
      ST_GAP:  if (gap_cnt == '0) state_d = ST_READ;
      ST_READ: if (read_exit || tmo_cnt == '0) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      gap_cnt  <= '0;
      tmo_cnt  <= '0;
      seen_out <= 1'b0;
      err_q    <= ERR_NONE;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: if (start) err_q <= cfg_ok ? ERR_NONE : ERR_CFG;
        ST_LOAD: begin
          gap_cnt <= GAP_W'(GAP_CYC - 1);
          if (underrun) err_q <= ERR_UNDERRUN;
        end
        ST_GAP: begin
          gap_cnt  <= gap_cnt - 1'b1;
          tmo_cnt  <= TMO_W'(TIMEOUT - 1);
          seen_out <= 1'b0;
        end
        ST_READ: begin
          tmo_cnt <= tmo_cnt - 1'b1;
          if (mod_valid_out) seen_out <= 1'b1;
          // An underrun is the root cause, so it is not masked by the timeout.
          if (!read_exit && tmo_cnt == '0 && err_q != ERR_UNDERRUN) err_q <= ERR_TIMEOUT;
        end
        default: ;
      endcase
    end
  end

  assign busy         = (state_q != ST_IDLE);
  assign done         = (state_q == ST_DONE);
  assign mod_enable   = (state_q == ST_READ);
  assign mod_valid_in = bit_valid;
  assign mod_data_in  = bit_valid & bit_data;
  assign err_code     = err_q;

endmodule

// File: tb/tb_ble_dqpsk_tx_sequencer.sv
// Bench for ble_dqpsk_tx_sequencer: burst timeline model, reactive modulator, per-cycle compare.
module tb_ble_dqpsk_tx_sequencer;
  import ble_dqpsk_seq_pkg::*;

  localparam int CNT_W = 10;
  localparam int RAM_DEPTH = 512;
  localparam int GAP_CYC = 1;
  localparam int TIMEOUT = 4096;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic [CNT_W-1:0] sym_count = '0;
  logic byte_valid = 1'b0;
  logic [7:0] byte_data = '0;
  logic byte_ready, mod_valid_in, mod_data_in, mod_enable;
  logic mod_valid_out = 1'b0;
  logic mod_finished = 1'b1;
  logic busy, done;
  logic [1:0] err_code;

  ble_dqpsk_tx_sequencer #(.CNT_W(CNT_W), .RAM_DEPTH(RAM_DEPTH), .GAP_CYC(GAP_CYC),
                           .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .start(start), .sym_count(sym_count),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .mod_valid_in(mod_valid_in), .mod_data_in(mod_data_in), .mod_enable(mod_enable),
    .mod_valid_out(mod_valid_out), .mod_finished(mod_finished),
    .busy(busy), .done(done), .err_code(err_code));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int pass_cnt = 0;
  int total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Burst timeline model: N = start edge, bits in N+1..L, READ from E, DONE at D.
  bit chk_en = 1'b0;
  int m_n, m_l, m_e, m_d;
  bit m_cfg;
  logic [1:0] m_err;
  logic [1023:0] exp_bits;
  logic [1023:0] got;
  int done_at;
  logic [7:0] src [0:3];

  always @(negedge clk) begin
    int c;
    if (chk_en) begin
      c = cyc;
      chk("busy", busy, (c >= m_n && c <= m_d));
      chk("done", done, (c == m_d));
      chk("mod_enable", mod_enable, (c >= m_e && c < m_d));
      chk("mod_valid_in", mod_valid_in, (c > m_n && c <= m_l));
      if (c > m_n && c <= m_l) begin
        chk("mod_data_in", mod_data_in, exp_bits[c-m_n-1]);
        got[c-m_n-1] = mod_data_in;
      end
      if (c == m_n) chk("byte_ready_first", byte_ready, !m_cfg);
      else if (c < m_n || c > m_l) chk("byte_ready_off", byte_ready, 0);
      if (c == m_n) chk("err_at_start", err_code, m_cfg ? 1 : 0);
      if (c >= m_d) chk("err_code", err_code, m_err);
      if (done) done_at = c;
    end
  end

  task automatic run_burst(input int sym, input int avail, input bit never_fin,
                           input bit poke_start, output int acc);
    int nb, exp_acc, mod_bits, out_left, guard;
    bit under, hs_pending, rd;
    m_cfg = (sym == 0 || sym > RAM_DEPTH);
    nb = 2 * sym;
    if (8 * avail < nb) nb = 8 * avail;
    if (m_cfg) nb = 0;
    under = !m_cfg && (8 * avail < 2 * sym);
    exp_acc = m_cfg ? 0 : (2 * sym + 7) / 8;
    if (exp_acc > avail) exp_acc = avail;
    exp_bits = '0;
    got = '0;
    done_at = -1;
    for (int i = 0; i < nb; i++) exp_bits[i] = src[i/8][i%8];
    @(negedge clk);
    m_n = cyc + 1;
    m_l = m_n + nb;
    m_e = m_cfg ? m_n : m_l + 1 + GAP_CYC;
    m_d = m_cfg ? m_n : (never_fin ? m_e + TIMEOUT : m_e + nb / 2 + 1);
    m_err = m_cfg ? ERR_CFG : (under ? ERR_UNDERRUN : (never_fin ? ERR_TIMEOUT : ERR_NONE));
    start = 1'b1;
    sym_count = CNT_W'(sym);
    acc = 0;
    byte_valid = (avail > 0);
    byte_data = src[0];
    hs_pending = 1'b0;
    mod_bits = 0;
    out_left = 0;
    rd = 1'b0;
    chk_en = 1'b1;
    guard = 0;
    while (cyc <= m_d + 2 && guard < TIMEOUT + 400) begin
      @(negedge clk);
      guard++;
      start = poke_start && (cyc == m_n + 3);
      sym_count = start ? '0 : CNT_W'(sym);
      if (hs_pending) acc++;
      byte_valid = (acc < avail);
      byte_data = src[acc < 4 ? acc : 3];
      hs_pending = byte_valid && byte_ready;
      if (mod_valid_in) begin
        mod_bits++;
        mod_finished = 1'b0;
      end
      if (mod_enable) begin
        if (!rd) begin
          rd = 1'b1;
          out_left = mod_bits / 2;
        end
        if (out_left > 0) begin
          mod_valid_out = 1'b1;
          out_left--;
        end else begin
          mod_valid_out = 1'b0;
          mod_finished = !never_fin;
        end
      end
    end
    chk_en = 1'b0;
    if (cyc <= m_d + 2) chk("burst_bound", 0, 1);
    chk("bytes_accepted", acc, exp_acc);
    start = 1'b0;
    byte_valid = 1'b0;
    mod_valid_out = 1'b0;
    mod_finished = 1'b1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_enable"}, mod_enable, 0);
    chk({tag, "_valid_in"}, mod_valid_in, 0);
    chk({tag, "_data_in"}, mod_data_in, 0);
    chk({tag, "_byte_ready"}, byte_ready, 0);
    chk({tag, "_err"}, err_code, 0);
  endtask

  initial begin
    int acc;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // 0xB4 -> 0,0,1,0,1,1,0,1; done 15 cycles after the start edge
    src[0] = 8'hB4; src[1] = 8'h00; src[2] = 8'h00; src[3] = 8'h00;
    run_burst(4, 1, 1'b0, 1'b1, acc);
    chk("t1_bits", got[7:0], 8'hB4);
    chk("t1_done_lat", done_at - m_n, 15);

    // 0xFF then low nibble of 0x5A; third byte must not be taken
    src[0] = 8'hFF; src[1] = 8'h5A; src[2] = 8'h33;
    run_burst(6, 3, 1'b0, 1'b0, acc);
    chk("t2_bits", got[11:0], 12'hAFF);
    chk("t2_bytes", acc, 2);
    chk("t2_done_lat", done_at - m_n, 6 + 12 + 12 / 2 + 1 - 6 + 2);

    // second byte withheld: underrun after 8 bits
    src[0] = 8'hA5;
    run_burst(8, 1, 1'b0, 1'b0, acc);
    chk("t3_bits", got[7:0], 8'hA5);
    chk("t3_err", err_code, 2);
    chk("t3_done_lat", done_at - m_n, 15);

    run_burst(0, 2, 1'b0, 1'b0, acc);
    chk("t4_err", err_code, 1);
    chk("t4_done_lat", done_at - m_n, 0);
    run_burst(600, 2, 1'b0, 1'b0, acc);
    chk("t5_err", err_code, 1);
    chk("t5_done_lat", done_at - m_n, 0);

    src[0] = 8'h3C;
    run_burst(4, 1, 1'b1, 1'b0, acc);
    chk("t6_err", err_code, 3);
    chk("t6_done_lat", done_at - m_n, 10 + TIMEOUT);

    // reset pulsed mid-LOAD, after an error was left in err_code
    @(negedge clk);
    start = 1'b1;
    sym_count = 10'd8;
    byte_valid = 1'b1;
    byte_data = 8'hC3;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("t7_mid_load_valid", mod_valid_in, 1);
    reset = 1'b1;
    byte_valid = 1'b0;
    @(negedge clk);
    chk_all_zero("midreset");
    reset = 1'b0;
    mod_finished = 1'b1;
    repeat (2) @(negedge clk);

    src[0] = 8'hB4;
    run_burst(4, 1, 1'b0, 1'b0, acc);
    chk("t8_bits", got[7:0], 8'hB4);
    chk("t8_err", err_code, 0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
